// File: rtl/mem_refill_arbiter.sv
// Burst memory port arbiter for icache refill and dcache refill/writeback.
// Ports: clk/rst, ic_req_*, dc_req_*/dc_wdata_*, *_rdata*, mem_*, grant, protocol_err.
module mem_refill_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 128,
  parameter int BURST_LEN  = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req_valid,
  output logic              ic_req_ready,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_rdata_valid,
  output logic [DATA_W-1:0] ic_rdata,
  input  logic              dc_req_valid,
  output logic              dc_req_ready,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic              dc_req_rnw,
  input  logic              dc_wdata_valid,
  output logic              dc_wdata_ready,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_rdata_valid,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  output logic              mem_cmd_rnw,
  output logic              mem_wdata_valid,
  input  logic              mem_wdata_ready,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rdata_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        grant,
  output logic              protocol_err
);

  localparam int CW =
    (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] LAST =
    CW'(BURST_LEN - 1);
  localparam logic [SW-1:0] SMAX =
    SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_RDATA,
    S_WDATA
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rnw;
  logic              r_owner_dc;
  logic [CW-1:0]     r_beat;
  logic [SW-1:0]     r_streak;
  logic              r_perr;

  logic w_idle;
  logic w_dc_win;
  logic w_ic_win;
  logic w_accept;
  logic w_rbeat;
  logic w_wbeat;
  logic w_last;

  // icache only beats dcache in a tie once the streak saturates
  assign w_dc_win = dc_req_valid &
    ~(ic_req_valid & (r_streak == SMAX));
  assign w_ic_win = ic_req_valid & ~w_dc_win;
  assign w_idle   = (r_state == S_IDLE) & ~rst;
  assign w_accept = w_idle & (w_dc_win | w_ic_win);
  assign w_rbeat  = (r_state == S_RDATA) &
    mem_rdata_valid;
  assign w_wbeat  = (r_state == S_WDATA) &
    dc_wdata_valid & mem_wdata_ready;
  assign w_last   = (r_beat == LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_accept) w_next = S_CMD;
      S_CMD:
        if (mem_cmd_ready)
          w_next = r_rnw ? S_RDATA : S_WDATA;
      S_RDATA:
        if (w_rbeat && w_last) w_next = S_IDLE;
      S_WDATA:
        if (w_wbeat && w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr     <= '0;
      r_rnw      <= 1'b0;
      r_owner_dc <= 1'b0;
      r_beat     <= '0;
      r_streak   <= '0;
      r_perr     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_beat     <= '0;
        r_owner_dc <= w_dc_win;
        if (w_dc_win) begin
          r_addr <= dc_req_addr;
          r_rnw  <= dc_req_rnw;
          if (!ic_req_valid)
            r_streak <= '0;
          else if (r_streak != SMAX)
            r_streak <= r_streak + SW'(1);
        end else begin
          r_addr   <= ic_req_addr;
          r_rnw    <= 1'b1;
          r_streak <= '0;
        end
      end else if (w_rbeat || w_wbeat) begin
        r_beat <= w_last ? '0 : r_beat + CW'(1);
      end
      // read beat with no read burst open is lost
      if (mem_rdata_valid && r_state != S_RDATA)
        r_perr <= 1'b1;
    end
  end

  assign mem_cmd_addr = r_addr;
  assign mem_cmd_rnw  = r_rnw;
  assign mem_wdata    = dc_wdata;
  assign ic_rdata     = mem_rdata;
  assign dc_rdata     = mem_rdata;
  assign protocol_err = r_perr;

  always_comb begin
    ic_req_ready    = 1'b0;
    dc_req_ready    = 1'b0;
    mem_cmd_valid   = 1'b0;
    ic_rdata_valid  = 1'b0;
    dc_rdata_valid  = 1'b0;
    mem_wdata_valid = 1'b0;
    dc_wdata_ready  = 1'b0;
    grant           = 2'b00;
    unique case (r_state)
      S_IDLE: begin
        ic_req_ready = w_idle & w_ic_win;
        dc_req_ready = w_idle & w_dc_win;
      end
      S_CMD: begin
        mem_cmd_valid = 1'b1;
        grant = r_owner_dc ? 2'b10 : 2'b01;
      end
      S_RDATA: begin
        ic_rdata_valid = mem_rdata_valid & ~r_owner_dc;
        dc_rdata_valid = mem_rdata_valid & r_owner_dc;
        grant = r_owner_dc ? 2'b10 : 2'b01;
      end
      S_WDATA: begin
        mem_wdata_valid = dc_wdata_valid;
        dc_wdata_ready  = mem_wdata_ready;
        grant = r_owner_dc ? 2'b10 : 2'b01;
      end
      default: grant = 2'b00;
    endcase
  end

endmodule
